// File: rtl/cla_adder_32_pkg.sv
// Shared constants, types and group generate/propagate helpers for the
// 32-bit carry-lookahead adder.
package cla_adder_32_pkg;

  localparam int WIDTH      = 32;
  localparam int BLOCK      = 4;
  localparam int NUM_BLOCKS = WIDTH / BLOCK;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Merge two adjacent groups; hi is the more significant one.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  function automatic logic gp_carry(input gp_t gp, input logic cin);
    return gp.g | (gp.p & cin);
  endfunction

endpackage

// File: rtl/cla_block_4.sv
// Four-wide lookahead cell: two-level carries from the block carry-in plus
// block generate/propagate. Used for both bit groups and block groups.
module cla_block_4
  import cla_adder_32_pkg::*;
(
  input  logic [BLOCK-1:0] g,
  input  logic [BLOCK-1:0] p,
  input  logic             cin,
  output logic [3:1]       c,
  output logic             gg,
  output logic             pp
);

  assign c[1] = g[0]
              | (p[0] & cin);

  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);

  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  // Group terms deliberately exclude cin so a parent level can chain them.
  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign pp = p[3] & p[2] & p[1] & p[0];

endmodule

// File: rtl/cla_adder_32.sv
// One-cycle 32-bit carry-lookahead adder stage: three lookahead levels
// (4-bit, 16-bit, 32-bit) feeding registered sum, carry-out and group G/P.
module cla_adder_32
  import cla_adder_32_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             G,
  output logic             P,
  output logic             c32,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0]      g_bit;
  logic [WIDTH-1:0]      p_bit;
  logic [WIDTH-1:0]      carry;

  logic [NUM_BLOCKS-1:0] blk_gg;
  logic [NUM_BLOCKS-1:0] blk_pp;
  logic [NUM_BLOCKS-1:0] blk_cin;
  logic [3:1]            blk_c [NUM_BLOCKS];

  logic [3:1]            lo_c;
  logic [3:1]            hi_c;
  logic                  lo_gg, lo_pp;
  logic                  hi_gg, hi_pp;
  logic                  c16;
  gp_t                   lo_gp, hi_gp, word_gp;

  logic [WIDTH-1:0]      sum_d, sum_q;
  logic                  c32_d, c32_q;
  logic                  g_d, g_q;
  logic                  p_d, p_q;

  assign g_bit = x & y;
  assign p_bit = x ^ y;

  // Level 1: eight 4-bit cells, each fed its carry-in from level 2.
  for (genvar k = 0; k < NUM_BLOCKS; k++) begin : gen_l1
    cla_block_4 u_blk (
      .g   (g_bit[BLOCK*k +: BLOCK]),
      .p   (p_bit[BLOCK*k +: BLOCK]),
      .cin (blk_cin[k]),
      .c   (blk_c[k]),
      .gg  (blk_gg[k]),
      .pp  (blk_pp[k])
    );

    assign carry[BLOCK*k]                 = blk_cin[k];
    assign carry[BLOCK*k+1 +: BLOCK-1]    = blk_c[k];
  end

  // Level 2: each cell spans four level-1 blocks (16 bits).
  cla_block_4 u_l2_lo (
    .g   (blk_gg[3:0]),
    .p   (blk_pp[3:0]),
    .cin (c_in),
    .c   (lo_c),
    .gg  (lo_gg),
    .pp  (lo_pp)
  );

  cla_block_4 u_l2_hi (
    .g   (blk_gg[7:4]),
    .p   (blk_pp[7:4]),
    .cin (c16),
    .c   (hi_c),
    .gg  (hi_gg),
    .pp  (hi_pp)
  );

  // Level 3: the two 16-bit halves reuse the 2-input lookahead equations.
  assign lo_gp   = '{g: lo_gg, p: lo_pp};
  assign hi_gp   = '{g: hi_gg, p: hi_pp};
  assign c16     = gp_carry(lo_gp, c_in);
  assign word_gp = gp_combine(hi_gp, lo_gp);

  assign blk_cin = {hi_c, c16, lo_c, c_in};

  always_comb begin
    sum_d = p_bit ^ carry;
    c32_d = gp_carry(word_gp, c_in);
    g_d   = word_gp.g;
    p_d   = word_gp.p;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
      c32_q <= 1'b0;
      g_q   <= 1'b0;
      p_q   <= 1'b0;
    end else begin
      sum_q <= sum_d;
      c32_q <= c32_d;
      g_q   <= g_d;
      p_q   <= p_d;
    end
  end

  assign sum = sum_q;
  assign c32 = c32_q;
  assign G   = g_q;
  assign P   = p_q;

endmodule

// File: tb/tb_cla_adder_32.sv
// Directed and random checks of cla_adder_32 against hand-computed values
// and a 33-bit reference sum, with one cycle of latency.
module tb_cla_adder_32;

  logic        clk;
  logic        reset;
  logic [31:0] x;
  logic [31:0] y;
  logic        c_in;
  logic        G;
  logic        P;
  logic        c32;
  logic [31:0] sum;

  int checks = 0;
  int errors = 0;

  cla_adder_32 dut (
    .clk   (clk),
    .reset (reset),
    .x     (x),
    .y     (y),
    .c_in  (c_in),
    .G     (G),
    .P     (P),
    .c32   (c32),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one operand set on the falling edge, then wait until just after
  // the rising edge that captures it.
  task automatic apply_stimulus(input logic rst, input logic [31:0] a,
                                input logic [31:0] b, input logic ci);
    @(negedge clk);
    reset = rst;
    x     = a;
    y     = b;
    c_in  = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] exp_sum,
                              input logic exp_c32, input logic exp_g,
                              input logic exp_p);
    checks++;
    assert (sum === exp_sum) else begin
      errors++;
      $error("[TB] FAIL %s sum actual=%h required=%h", tag, sum, exp_sum);
    end
    checks++;
    assert (c32 === exp_c32) else begin
      errors++;
      $error("[TB] FAIL %s c32 actual=%b required=%b", tag, c32, exp_c32);
    end
    checks++;
    assert (G === exp_g) else begin
      errors++;
      $error("[TB] FAIL %s G actual=%b required=%b", tag, G, exp_g);
    end
    checks++;
    assert (P === exp_p) else begin
      errors++;
      $error("[TB] FAIL %s P actual=%b required=%b", tag, P, exp_p);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] ref_sum;
    logic [32:0] ref_gen;

    reset = 1'b1;
    x     = '0;
    y     = '0;
    c_in  = 1'b0;
    $display("[TB] start");

    apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    check_output("reset_initial", 32'h0, 1'b0, 1'b0, 1'b0);

    apply_stimulus(1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    check_output("full_chain", 32'h0, 1'b1, 1'b1, 1'b0);

    apply_stimulus(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
    check_output("propagate_cin0", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);

    apply_stimulus(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    check_output("propagate_cin1", 32'h0, 1'b1, 1'b0, 1'b1);

    apply_stimulus(1'b0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    check_output("boundary_16", 32'h0001_0000, 1'b0, 1'b0, 1'b0);

    apply_stimulus(1'b0, 32'h0000_000F, 32'h0000_0001, 1'b0);
    check_output("boundary_4", 32'h0000_0010, 1'b0, 1'b0, 1'b0);

    apply_stimulus(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check_output("boundary_31", 32'h8000_0000, 1'b0, 1'b0, 1'b0);

    apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check_output("all_ones_cin1", 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);

    apply_stimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    check_output("cin_through_word", 32'h0, 1'b1, 1'b0, 1'b1);

    apply_stimulus(1'b0, 32'h00FF_0000, 32'h0001_0000, 1'b0);
    check_output("upper_half_chain", 32'h0100_0000, 1'b0, 1'b0, 1'b0);

    // Back-to-back operands, one result per cycle.
    apply_stimulus(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0);
    check_output("pipe_0", 32'h7, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    check_output("pipe_1", 32'h1, 1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    check_output("pipe_2", 32'h0, 1'b0, 1'b0, 1'b0);

    // Reset mid-stream beats valid operands, then the next edge recovers.
    apply_stimulus(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    check_output("pre_reset", 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check_output("reset_midstream", 32'h0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b1);
    check_output("post_reset", 32'h0000_0031, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      ra = $urandom();
      rb = $urandom();
      rc = 1'($urandom_range(1, 0));
      if (i % 8 == 0) rb = ~ra;
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      ref_gen = {1'b0, ra} + {1'b0, rb};
      apply_stimulus(1'b0, ra, rb, rc);
      check_output("random", ref_sum[31:0], ref_sum[32], ref_gen[32], &(ra ^ rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
